// File: rtl/bru_pkg.sv
// Shared types and constants for the EX-stage branch resolution controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bru_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    // RV32I branch funct3 encodings; 010 and 011 are reserved.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational taken/target/fall-through/misalign/illegal decode for one EX control transfer.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs, the caller decides when they are sampled.
// Ports: instruction class + funct3, pc/imm/rs1 operands, comparator flags in;
//        o_taken, o_target, o_fall_through, o_misalign (taken & target not word aligned),
//        o_illegal (reserved branch funct3) out.
module branch_target_calc
    import bru_pkg::*;
(
    input  logic        i_is_branch,
    input  logic        i_is_jal,
    input  logic        i_is_jalr,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_rs1,
    input  logic        i_br_equal,
    input  logic        i_br_less,
    output logic        o_taken,
    output logic [31:0] o_target,
    output logic [31:0] o_fall_through,
    output logic        o_misalign,
    output logic        o_illegal
);

    logic        cond;
    logic        bad_f3;
    logic [31:0] jalr_sum;

    // Signed vs unsigned is already folded into i_br_less by the comparator
    // (driven from funct3[1]), so BLT/BLTU and BGE/BGEU share a condition.
    always_comb begin
        cond   = 1'b0;
        bad_f3 = 1'b0;
        case (i_funct3)
            F3_BEQ:           cond = i_br_equal;
            F3_BNE:           cond = ~i_br_equal;
            F3_BLT, F3_BLTU:  cond = i_br_less;
            F3_BGE, F3_BGEU:  cond = ~i_br_less;
            default:          bad_f3 = 1'b1;
        endcase
    end

    assign jalr_sum       = i_rs1 + i_imm;
    assign o_illegal      = i_is_branch & bad_f3;
    assign o_taken        = i_is_jal | i_is_jalr | (i_is_branch & cond);
    assign o_target       = i_is_jalr ? {jalr_sum[31:1], 1'b0} : (i_pc + i_imm);
    assign o_fall_through = i_pc + PC_STEP;
    assign o_misalign     = o_taken & (o_target[1:0] != 2'b00);

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch/jump resolution: checks the IF prediction and sequences redirect + front-end flush.
// Latency: mispredict resolved in cycle N -> redirect/flush in N+1; next resolve in N+2+FLUSH_CYCLES.
// Backpressure: i_stall blocks resolution in IDLE and freezes the flush countdown; REDIRECT ignores it.
// Ports: i_clk/i_rst (sync, active high); EX instruction fields, prediction and comparator flags in;
//        o_br_un (comb), o_redirect/o_redirect_pc, o_flush_if/o_flush_id, o_misalign, o_illegal, o_busy out.
// Build option BRU_PERF_CNT_EN adds saturating o_br_cnt / o_mispred_cnt of width CNT_W.
module branch_resolve_ctrl
    import bru_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1
`ifdef BRU_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_is_branch,
    input  logic        i_is_jal,
    input  logic        i_is_jalr,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_rs1,
    input  logic        i_pred_taken,
    input  logic [31:0] i_pred_target,
    input  logic        i_br_equal,
    input  logic        i_br_less,
    input  logic        i_stall,
    output logic        o_br_un,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_flush_if,
    output logic        o_flush_id,
    output logic        o_misalign,
    output logic        o_illegal,
    output logic        o_busy
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
`endif
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        redirect_q, redirect_d;
    logic        flush_q, flush_d;
    logic        misalign_q, misalign_d;
    logic        illegal_q, illegal_d;

    logic        taken;
    logic [31:0] target;
    logic [31:0] fall_through;
    logic        tgt_misalign;
    logic        f3_illegal;
    logic        resolve;
    logic        mispredict;
    logic [31:0] correct_pc;

    // Comparator select is needed in the same cycle the operands arrive.
    assign o_br_un = i_funct3[1];

    branch_target_calc u_calc (
        .i_is_branch    (i_is_branch),
        .i_is_jal       (i_is_jal),
        .i_is_jalr      (i_is_jalr),
        .i_funct3       (i_funct3),
        .i_pc           (i_pc),
        .i_imm          (i_imm),
        .i_rs1          (i_rs1),
        .i_br_equal     (i_br_equal),
        .i_br_less      (i_br_less),
        .o_taken        (taken),
        .o_target       (target),
        .o_fall_through (fall_through),
        .o_misalign     (tgt_misalign),
        .o_illegal      (f3_illegal)
    );

    // Anything arriving while REDIRECT/FLUSH is wrong-path and never resolves.
    assign resolve    = i_valid & ~i_stall & (state_q == IDLE);
    assign mispredict = (taken != i_pred_taken) | (taken & (target != i_pred_target));
    assign correct_pc = taken ? target : fall_through;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        redirect_pc_d = redirect_pc_q;
        misalign_d    = 1'b0;
        illegal_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (resolve) begin
                    // Priority: illegal, then misaligned trap, then mispredict.
                    if (f3_illegal) begin
                        illegal_d = 1'b1;
                    end else if (tgt_misalign) begin
                        misalign_d = 1'b1;
                    end else if (mispredict) begin
                        state_d       = REDIRECT;
                        redirect_pc_d = correct_pc;
                    end
                end
            end
            REDIRECT: begin
                cnt_d   = FLUSH_LOAD;
                state_d = (FLUSH_CYCLES > 0) ? FLUSH : IDLE;
            end
            FLUSH: begin
                if (!i_stall) begin
                    if (cnt_q == 3'd1) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Output flags are registered off the next state so they line up with it.
        redirect_d = (state_d == REDIRECT);
        flush_d    = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            redirect_pc_q <= 32'h0;
            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
            misalign_q    <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            redirect_pc_q <= redirect_pc_d;
            redirect_q    <= redirect_d;
            flush_q       <= flush_d;
            misalign_q    <= misalign_d;
            illegal_q     <= illegal_d;
        end
    end

    assign o_redirect    = redirect_q;
    assign o_redirect_pc = redirect_pc_q;
    assign o_flush_if    = flush_q;
    assign o_flush_id    = flush_q;
    assign o_misalign    = misalign_q;
    assign o_illegal     = illegal_q;
    assign o_busy        = flush_q;

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;
    logic             br_inc;
    logic             mispred_inc;

    assign br_inc      = resolve & ~f3_illegal;
    assign mispred_inc = (state_q == IDLE) & (state_d == REDIRECT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (br_inc && (br_cnt_q != '1)) begin
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            end
            if (mispred_inc && (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_br_cnt      = br_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
EX-stage branch/jump resolution controller for the pipelined RV32I core. Drives the branch comparator's unsigned-select input and consumes its equal/less flags. Decides taken/target, checks the IF-stage prediction, and on mispredict sequences the redirect-and-flush of the front end.

Parameters:
FLUSH_CYCLES, 1, extra cycles of front-end flush after the redirect cycle (0..7)
CNT_W, 32, width of the performance counters (optional feature only)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous active-high reset
i_valid  in  1  EX holds a control-transfer instruction
i_is_branch / i_is_jal / i_is_jalr  in  1 each  instruction class, one-hot when i_valid
i_funct3  in  3  branch funct3
i_pc  in  32  PC of the EX instruction
i_imm  in  32  sign-extended immediate
i_rs1  in  32  forwarded rs1, used for the JALR target
i_pred_taken  in  1  IF prediction
i_pred_target  in  32  IF predicted target
i_br_equal, i_br_less  in  1 each  comparator flags
i_stall  in  1  pipeline stall from the hazard unit
o_br_un  out  1  comparator unsigned select
o_redirect  out  1  one-cycle PC redirect strobe
o_redirect_pc  out  32  corrected PC
o_flush_if, o_flush_id  out  1 each  squash IF/ID registers
o_misalign  out  1  one-cycle pulse: taken target not 4-byte aligned
o_illegal  out  1  one-cycle pulse: funct3 010/011 on a branch
o_busy  out  1  state != IDLE

Behaviour:
- o_br_un = i_funct3[1]. Combinational at all times, and valid during reset.
- Taken conditions: BEQ=eq; BNE=!eq; BLT/BLTU=less; BGE/BGEU=!less; JAL/JALR always taken.
- Illegal funct3 010/011 means not taken.
- Targets:
  - Branch/JAL target = i_pc+i_imm.
  - JALR target = (i_rs1+i_imm) & ~32'h1.
  - Fall-through = i_pc+4.
  - All sums are 32-bit and wrap mod 2^32.
- Resolve event = i_valid & ~i_stall & state==IDLE. Only resolve events are evaluated.
- Mispredict = (taken != i_pred_taken) | (taken & target != i_pred_target).
- Correct PC = target if taken, else fall-through.
- All outputs except o_br_un are registered. Their reset value is 0, including o_redirect_pc=32'h0. State resets to IDLE.
- FSM:
  - IDLE: on a resolve event, exactly one of the following applies.
    - Illegal: o_illegal=1 next cycle, stay IDLE.
    - Taken & target[1:0]!=0: o_misalign=1 next cycle, no redirect, stay IDLE. The trap is handled elsewhere.
    - Mispredict: go to REDIRECT and latch the correct PC into o_redirect_pc.
    - Otherwise stay IDLE.
  - REDIRECT (exactly 1 cycle, stall ignored): o_redirect=1, o_flush_if=1, o_flush_id=1. Load cnt=FLUSH_CYCLES. Next state is FLUSH if FLUSH_CYCLES>0, else IDLE.
  - FLUSH: o_flush_if=o_flush_id=1 and o_redirect=0. cnt decrements only when ~i_stall. At cnt==1 with ~i_stall, go to IDLE.
- i_valid in REDIRECT/FLUSH is a wrong-path instruction. It is ignored: no pulse, no counter update.
- o_redirect_pc holds its value until the next mispredict.
- Latency: mispredict resolved in cycle N gives redirect/flush in N+1, and the next resolve is possible in N+2+FLUSH_CYCLES when there is no stall.
- i_rst in any state: next cycle IDLE with all registered outputs 0. Reset wins over a simultaneous resolve event.

Optional Feature:
Macro BRU_PERF_CNT_EN.
- With the macro: adds outputs o_br_cnt[CNT_W] and o_mispred_cnt[CNT_W], both reset to 0.
  - o_br_cnt increments on every resolve event that is not illegal.
  - o_mispred_cnt increments on every resolve event entering REDIRECT.
  - Both saturate at all-ones.
- Without the macro: the ports and registers are absent, and behaviour is otherwise identical.

Decomposition:
- Package bru_pkg holds:
  - enum state_e {IDLE, REDIRECT, FLUSH};
  - funct3 localparams F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU;
  - the PC_STEP=4 constant.
- One natural sub-module: branch_target_calc, a combinational block for taken, target, fall-through and misalign. The FSM and counters stay in the top module.

Test Plan:
- Reset, then BEQ at pc=0x100, imm=0x20, eq=1, pred_taken=1, pred_target=0x120 -> no redirect, o_busy=0.
- BLTU funct3=110, less=1, pred_taken=0, pc=0x200, imm=-8 -> o_br_un=1; next cycle o_redirect=1, o_redirect_pc=0x1F8, flush high for 1+FLUSH_CYCLES cycles; i_valid during flush is ignored.
- BNE predicted taken to 0x400, eq=1, pc=0x300 -> redirect to 0x304; mid-FLUSH i_stall=1 for 3 cycles -> flush extended by exactly 3 cycles.
- JALR rs1=0x1001, imm=0x0, pred_target=0x1000 -> target 0x1000, no redirect. Repeat with rs1=0x1002 -> o_misalign pulse, no redirect.
- funct3=010 branch -> o_illegal pulse for 1 cycle, state stays IDLE, counters (BRU_PERF_CNT_EN) unchanged.
- Mispredict resolved with i_rst asserted the same cycle -> next cycle IDLE, o_redirect=0, o_redirect_pc=0. With BRU_PERF_CNT_EN and CNT_W=4, 20 mispredicts -> o_mispred_cnt saturates at 15.
